// File: rtl/morse_pkg.sv
// Shared Morse-link definitions: letter codes, decoder FSM encoding,
// timing thresholds in sample units, and the per-letter symbol tables
// that both the transmitter and the receiver are built from.
package morse_pkg;

  // Letter codes as carried on the transmitter switches and decoder output
  localparam logic [2:0] LTR_Q = 3'd0;
  localparam logic [2:0] LTR_R = 3'd1;
  localparam logic [2:0] LTR_S = 3'd2;
  localparam logic [2:0] LTR_T = 3'd3;
  localparam logic [2:0] LTR_U = 3'd4;
  localparam logic [2:0] LTR_V = 3'd5;
  localparam logic [2:0] LTR_W = 3'd6;
  localparam logic [2:0] LTR_X = 3'd7;

  // Decoder FSM states
  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MARK  = 2'd2,
    ST_SPACE = 2'd3
  } morse_state_t;

  // Run-length thresholds, in sample strobes (4 samples per Morse unit)
  localparam logic [3:0] DOT_MIN  = 4'd3;
  localparam logic [3:0] DOT_MAX  = 4'd5;
  localparam logic [3:0] DASH_MIN = 4'd10;
  localparam logic [3:0] DASH_MAX = 4'd14;
  localparam logic [3:0] GAP_MIN  = 4'd3;
  localparam logic [3:0] END_LEN  = 4'd6;
  localparam logic [3:0] RUN_MAX  = 4'd15;

  // Longest letter in the alphabet; a fifth symbol is always malformed
  localparam logic [2:0] MAX_SYMS = 3'd4;

  // Per-letter symbol count and left-aligned pattern (dash=1, dot=0)
  localparam logic [2:0] LEN_Q = 3'd4;  localparam logic [3:0] PAT_Q = 4'b1101;
  localparam logic [2:0] LEN_R = 3'd3;  localparam logic [3:0] PAT_R = 4'b0100;
  localparam logic [2:0] LEN_S = 3'd3;  localparam logic [3:0] PAT_S = 4'b0000;
  localparam logic [2:0] LEN_T = 3'd1;  localparam logic [3:0] PAT_T = 4'b1000;
  localparam logic [2:0] LEN_U = 3'd3;  localparam logic [3:0] PAT_U = 4'b0010;
  localparam logic [2:0] LEN_V = 3'd4;  localparam logic [3:0] PAT_V = 4'b0001;
  localparam logic [2:0] LEN_W = 3'd3;  localparam logic [3:0] PAT_W = 4'b0110;
  localparam logic [2:0] LEN_X = 3'd4;  localparam logic [3:0] PAT_X = 4'b1001;

  // Tables indexed by letter code
  localparam logic [7:0][2:0] LETTER_LEN = {LEN_X, LEN_W, LEN_V, LEN_U,
                                            LEN_T, LEN_S, LEN_R, LEN_Q};
  localparam logic [7:0][3:0] LETTER_PAT = {PAT_X, PAT_W, PAT_V, PAT_U,
                                            PAT_T, PAT_S, PAT_R, PAT_Q};

  typedef struct packed {
    logic       hit;
    logic [2:0] code;
  } decode_t;

  // Match a collected symbol buffer against the alphabet
  function automatic decode_t decode_letter(input logic [2:0] len,
                                            input logic [3:0] pat);
    decode_t d;
    d.hit  = 1'b0;
    d.code = LTR_Q;
    for (int i = 0; i < 8; i++) begin
      if (!d.hit && (LETTER_LEN[i] == len) && (LETTER_PAT[i] == pat)) begin
        d.hit  = 1'b1;
        d.code = 3'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/morse_sample_tick.sv
// Sample-strobe prescaler: one-clock tick every SAMPLE_DIV clocks.
// The count restarts at 0 on reset, so the first tick lands on the
// SAMPLE_DIV-th clock edge after reset is released.
module morse_sample_tick #(
  parameter int SAMPLE_DIV = 6_250_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running modulo-SAMPLE_DIV counter
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: synchronizes the line, measures mark/space run lengths
// on sample strobes and rebuilds the 3-bit letter code.
// Optional feature: define MORSE_DECODER_ERRCNT_EN to get a saturating
// error counter on err_count; otherwise err_count is tied to zero.
//
// Output protocol: letter_valid and letter_err are single-clock event
// pulses with no backpressure; letter is stable from the letter_valid
// pulse until the next one. busy is high whenever the FSM is not IDLE.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int SAMPLE_DIV = 6_250_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic       busy,
  output logic [7:0] err_count
);

  logic         tick;
  logic         sync1;
  logic         sample;
  logic         prev_sample;
  logic [3:0]   run;
  logic [3:0]   run_next;
  morse_state_t state;
  morse_state_t state_next;
  logic [3:0]   sym_buf;
  logic [2:0]   sym_len;
  logic         is_dot;
  logic         is_dash;
  logic         mark_ok;
  logic         gap_short;
  logic         letter_end;
  decode_t      dec;
  logic         do_push;
  logic         do_valid;
  logic         do_err;
  logic         do_clear;

  morse_sample_tick #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .tick    (tick)
  );

  // Two-flop synchronizer for the asynchronous line
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1  <= 1'b0;
      sample <= 1'b0;
    end else begin
      sync1  <= morse_in;
      sample <= sync1;
    end
  end

  // Length of the current line run including this sample; saturates at 15
  always_comb begin
    run_next = 4'd1;
    if (sample == prev_sample) begin
      run_next = (run == RUN_MAX) ? RUN_MAX : run + 4'd1;
    end
  end

  // Run counter and previous-sample register advance only on strobes
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      run         <= 4'd0;
      prev_sample <= 1'b0;
    end else if (tick) begin
      run         <= run_next;
      prev_sample <= sample;
    end
  end

  // Classification of the run that just ended (run still holds its length)
  assign is_dot     = (run >= DOT_MIN) && (run <= DOT_MAX);
  assign is_dash    = (run >= DASH_MIN) && (run <= DASH_MAX);
  assign mark_ok    = (is_dot || is_dash) && (sym_len != MAX_SYMS);
  assign gap_short  = (run < GAP_MIN);
  assign letter_end = (run_next == END_LEN);
  assign dec        = decode_letter(sym_len, sym_buf);

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= ST_DRAIN;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; every error path leads back to DRAIN
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        ST_DRAIN: begin
          if (!sample && (run_next >= END_LEN)) state_next = ST_IDLE;
        end
        ST_IDLE: begin
          if (sample) state_next = ST_MARK;
        end
        ST_MARK: begin
          if (!sample) state_next = mark_ok ? ST_SPACE : ST_DRAIN;
        end
        ST_SPACE: begin
          if (sample) begin
            state_next = gap_short ? ST_DRAIN : ST_MARK;
          end else if (letter_end) begin
            state_next = dec.hit ? ST_IDLE : ST_DRAIN;
          end
        end
        default: state_next = ST_DRAIN;
      endcase
    end
  end

  // FSM event outputs for the current strobe
  always_comb begin
    do_push  = 1'b0;
    do_valid = 1'b0;
    do_err   = 1'b0;
    if (tick) begin
      case (state)
        ST_MARK: begin
          if (!sample) begin
            do_push = mark_ok;
            do_err  = !mark_ok;
          end
        end
        ST_SPACE: begin
          if (sample) begin
            do_err = gap_short;
          end else if (letter_end) begin
            do_valid = dec.hit;
            do_err   = !dec.hit;
          end
        end
        default: ;
      endcase
    end
    do_clear = do_err || (tick && (state == ST_IDLE));
  end

  // Symbol buffer: first symbol lands in bit 3, later ones fill downward
  always_ff @(posedge CLOCK_50) begin
    if (reset || do_clear) begin
      sym_buf <= 4'd0;
      sym_len <= 3'd0;
    end else if (do_push) begin
      sym_buf[2'd3 - sym_len[1:0]] <= is_dash;
      sym_len                      <= sym_len + 3'd1;
    end
  end

  // Registered result pulses and held letter code
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      letter       <= LTR_Q;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
    end else begin
      letter_valid <= do_valid;
      letter_err   <= do_err;
      if (do_valid) letter <= dec.code;
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef MORSE_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating error counter, updated together with the letter_err pulse
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (do_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder with a 4-clock sample strobe. Stimulus is
// expressed in samples; a dot/dash string model computes the expected
// outputs and a per-cycle compare process checks them.
module tb_morse_decoder;
  import morse_pkg::*;

  localparam int DIV = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       morse_in = 1'b0;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_err;
  logic       busy;
  logic [7:0] err_count;

  // ---------------- clock / reset ----------------
  always #5 CLOCK_50 = ~CLOCK_50;

  morse_decoder #(
    .SAMPLE_DIV(DIV)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .morse_in    (morse_in),
    .letter      (letter),
    .letter_valid(letter_valid),
    .letter_err  (letter_err),
    .busy        (busy),
    .err_count   (err_count)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int obs_valid = 0;
  int obs_err   = 0;
  bit chk_en    = 1'b0;

  // ---------------- reference model ----------------
  string morse_tab [8] = '{"--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-"};
  int         m_mode;   // 0 drain, 1 idle, 2 in mark, 3 in space
  int         m_run;
  bit         m_prev;
  string      m_syms;
  logic       exp_valid;
  logic       exp_err;
  logic       exp_busy;
  logic [2:0] exp_letter;
  logic [7:0] exp_errcnt;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode     = 0;
    m_run      = 0;
    m_prev     = 1'b0;
    m_syms     = "";
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
    exp_busy   = 1'b1;
    exp_letter = 3'd0;
    exp_errcnt = 8'd0;
    exp_q.delete();
  endtask

  // One sample of line level v as seen by a strobe
  task automatic model_step(input bit v);
    int run_n;
    int hit;
    bit err;
    err   = 1'b0;
    hit   = -1;
    run_n = (v != m_prev) ? 1 : ((m_run >= 15) ? 15 : m_run + 1);
    case (m_mode)
      0: if (!v && run_n >= 6) m_mode = 1;
      1: begin
        m_syms = "";
        if (v) m_mode = 2;
      end
      2: if (!v) begin
        if (m_syms.len() >= 4) err = 1'b1;
        else if (m_run >= 3 && m_run <= 5) begin m_syms = {m_syms, "."}; m_mode = 3; end
        else if (m_run >= 10 && m_run <= 14) begin m_syms = {m_syms, "-"}; m_mode = 3; end
        else err = 1'b1;
      end
      default: begin
        if (v) begin
          if (m_run < 3) err = 1'b1;
          else m_mode = 2;
        end else if (run_n == 6) begin
          for (int i = 0; i < 8; i++) if (m_syms == morse_tab[i]) hit = i;
          if (hit >= 0) begin
            exp_valid  = 1'b1;
            exp_letter = 3'(hit);
            exp_q.push_back(8'(hit));
            m_mode = 1;
          end else begin
            err = 1'b1;
          end
        end
      end
    endcase
    if (err) begin
      exp_err = 1'b1;
`ifdef MORSE_DECODER_ERRCNT_EN
      if (exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'd1;
`endif
      m_syms = "";
      m_mode = 0;
    end
    m_prev   = v;
    m_run    = run_n;
    exp_busy = (m_mode != 1);
  endtask

  // ---------------- driver tasks ----------------
  // Entry/exit point: 1 time unit after a strobe edge
  task automatic send_sample(input bit v);
    morse_in = v;
    @(posedge CLOCK_50);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    repeat (DIV - 2) @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    model_step(v);
    #1;
  endtask

  task automatic send_run(input bit v, input int n);
    repeat (n) send_sample(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge CLOCK_50);
    model_reset();
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
  endtask

  // Transmitter-style sender built from the shared letter tables
  task automatic tx_letter(input logic [2:0] sw);
    int n;
    logic [3:0] pat;
    n   = int'(LETTER_LEN[sw]);
    pat = LETTER_PAT[sw];
    for (int k = 0; k < n; k++) begin
      send_run(1'b1, pat[3-k] ? 12 : 4);
      if (k < n - 1) send_run(1'b0, 4);
    end
    send_run(1'b0, 12);
  endtask

  // ---------------- scoreboard / per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (chk_en) begin
        check("cyc_valid", 8'(letter_valid), 8'(exp_valid));
        check("cyc_err", 8'(letter_err), 8'(exp_err));
        check("cyc_busy", 8'(busy), 8'(exp_busy));
        check("cyc_letter", 8'(letter), 8'(exp_letter));
        check("cyc_errcnt", err_count, exp_errcnt);
        if (letter_valid) begin
          obs_valid++;
          if (exp_q.size() > 0) begin
            check("sb_letter", 8'(letter), exp_q.pop_front());
          end else begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: letter_valid with letter %0h and no expected entry at %0t", letter, $time);
          end
        end
        if (letter_err) obs_err++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int v0;
    int e0;
    int nsym;
    int kind;
    int ml;

    do_reset();
    chk_en = 1'b1;
    check("reset_busy", 8'(busy), 8'd1);
    check("reset_letter", 8'(letter), 8'd0);
    check("reset_errcnt", err_count, 8'd0);

    // Drain after reset, then T
    send_run(1'b0, 5);
    check("drain_busy_hold", 8'(busy), 8'd1);
    send_run(1'b0, 1);
    check("drain_busy_low", 8'(busy), 8'd0);
    v0 = obs_valid;
    send_run(1'b1, 12);
    send_run(1'b0, 6);
    check("t_letter", 8'(letter), 8'b011);
    send_run(1'b0, 2);
    check("t_pulses", 8'(obs_valid - v0), 8'd1);

    // Q: dash dash dot dash
    v0 = obs_valid; e0 = obs_err;
    send_run(1'b1, 12); send_run(1'b0, 4);
    send_run(1'b1, 12); send_run(1'b0, 4);
    send_run(1'b1, 4);  send_run(1'b0, 4);
    send_run(1'b1, 12); send_run(1'b0, 8);
    check("q_letter", 8'(letter), 8'b000);
    check("q_pulses", 8'(obs_valid - v0), 8'd1);
    check("q_errs", 8'(obs_err - e0), 8'd0);

    // Bad 7-sample mark, then S
    send_run(1'b1, 7);
    send_run(1'b0, 1);
    check("mark7_err", 8'(letter_err), 8'd1);
`ifdef MORSE_DECODER_ERRCNT_EN
    check("mark7_errcnt", err_count, 8'd1);
`endif
    send_run(1'b0, 9);
    send_run(1'b1, 4); send_run(1'b0, 4);
    send_run(1'b1, 4); send_run(1'b0, 4);
    send_run(1'b1, 4); send_run(1'b0, 8);
    check("s_letter", 8'(letter), 8'b010);

    // Five dots overflow the buffer
    v0 = obs_valid; e0 = obs_err;
    repeat (4) begin
      send_run(1'b1, 4);
      send_run(1'b0, 4);
    end
    send_run(1'b1, 4);
    send_run(1'b0, 1);
    check("dots5_err", 8'(letter_err), 8'd1);
    send_run(1'b0, 10);
    check("dots5_valid", 8'(obs_valid - v0), 8'd0);
    check("dots5_errs", 8'(obs_err - e0), 8'd1);

    // Reset in the middle of X's final dash, then W
    v0 = obs_valid; e0 = obs_err;
    send_run(1'b1, 12); send_run(1'b0, 4);
    send_run(1'b1, 4);  send_run(1'b0, 4);
    send_run(1'b1, 4);  send_run(1'b0, 4);
    send_run(1'b1, 6);
    do_reset();
    check("rst_busy", 8'(busy), 8'd1);
    check("rst_letter", 8'(letter), 8'd0);
    send_run(1'b0, 5);
    check("rst_drain_busy", 8'(busy), 8'd1);
    send_run(1'b0, 1);
    check("rst_idle_busy", 8'(busy), 8'd0);
    check("rst_no_valid", 8'(obs_valid - v0), 8'd0);
    check("rst_no_err", 8'(obs_err - e0), 8'd0);
    send_run(1'b1, 4);  send_run(1'b0, 4);
    send_run(1'b1, 12); send_run(1'b0, 4);
    send_run(1'b1, 12); send_run(1'b0, 8);
    check("w_letter", 8'(letter), 8'b110);

    // Loopback through the table-driven transmitter
    for (int sw = 0; sw < 8; sw++) begin
      tx_letter(3'(sw));
      check("loop_letter", 8'(letter), 8'(sw));
    end

    // Randomized runs: mostly legal symbols, some bad marks/gaps and resets
    for (int n = 0; n < 50; n++) begin
      nsym = int'($urandom_range(1, 5));
      for (int k = 0; k < nsym; k++) begin
        kind = int'($urandom_range(0, 5));
        case (kind)
          0, 1:    ml = int'($urandom_range(3, 5));
          2, 3:    ml = int'($urandom_range(10, 14));
          4:       ml = int'($urandom_range(1, 18));
          default: ml = int'($urandom_range(2, 16));
        endcase
        send_run(1'b1, ml);
        if ($urandom_range(0, 40) == 0) do_reset();
        if (k < nsym - 1) begin
          if ($urandom_range(0, 4) == 0) send_run(1'b0, int'($urandom_range(1, 2)));
          else send_run(1'b0, int'($urandom_range(3, 5)));
        end
      end
      send_run(1'b0, int'($urandom_range(6, 12)));
    end
    send_run(1'b0, 8);
    check("sb_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receive-side stage for the Morse link: consumes the serial on/off line driven by the Morse transmitter, measures mark/space durations with an oversampling strobe, and reconstructs the transmitted letter. It outputs the same 3-bit letter code the transmitter takes on its switch inputs, so a loopback reproduces the selected code. It sits directly downstream of the transmitter's output bit.

## Interface
- SAMPLE_DIV, 6_250_000: CLOCK_50 cycles per sample strobe; 4 samples per 0.5 s Morse unit.
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- morse_in  in  1  asynchronous Morse line, 1 = mark
- letter  out  3  decoded code: Q=000 R=001 S=010 T=011 U=100 V=101 W=110 X=111
- letter_valid  out  1  one-clock pulse, letter valid this cycle
- letter_err  out  1  one-clock pulse on malformed or unknown input
- busy  out  1  high while not in IDLE
- err_count  out  8  saturating error count (see Configuration)

## Operation
- morse_in passes through a 2-FF synchronizer; FSM and run counter advance only on sample strobes.
- Run counter: 4 bits, saturates at 15; reloads to 1 on each line transition.
- Symbol buffer: 4-bit shift register, first symbol in bit 3, dash=1, dot=0, unused bits 0; 3-bit length counter.
- States:
  - DRAIN: wait for 6 consecutive low samples, then IDLE. Line high restarts the count.
  - IDLE: buffer cleared; high sample -> MARK.
  - MARK: count high samples. On the first low sample, classify the run.
    - 3..5 -> dot
    - 10..14 -> dash
    - any other length -> error
    - A push that would make length 5 -> error.
    - A valid symbol is pushed and the FSM goes to SPACE.
  - SPACE: count low samples.
    - High sample after 1..2 lows -> error.
    - High sample after 3..5 lows -> MARK.
    - Low count reaching 6 -> decode.
  - Decode: (length, pattern) matched against the 8 letters: Q 4/1101, R 3/0100, S 3/0000, T 1/1000, U 3/0010, V 4/0001, W 3/0110, X 4/1001.
    - Match -> letter_valid pulse, go to IDLE.
    - No match -> error.
  - Error from any state: letter_err pulse, buffer cleared, go to DRAIN.
- A mark reaching 15 samples saturates the counter; classification happens when the mark ends, so the result is an error.
- letter holds its last decoded value between pulses; reset value 000.
- Reset values: letter=000, letter_valid=0, letter_err=0, busy=1 (DRAIN), err_count=0, synchronizer=0.
- Reset mid-letter: partial letter discarded, no pulse; the decoder re-enters DRAIN.

## Timing
- Strobe period: SAMPLE_DIV clocks; the prescaler restarts at 0 on reset.
- Synchronizer latency: 2 clocks before morse_in is visible to a strobe.
- letter_valid / letter_err are registered: they assert on the clock after the deciding strobe and last exactly 1 clock.
- Letter latency: 6 sample strobes after the last mark falls, plus 3 clocks.
- Error and decode on the same strobe cannot coincide; error takes priority by construction.

## Configuration
- MORSE_DECODER_ERRCNT_EN defined:
  - err_count increments on each letter_err pulse.
  - Saturates at 255.
  - Clears only on reset.
- Undefined:
  - Counter logic is omitted.
  - err_count is tied to 8'd0.
  - Port list is unchanged.

## Structure
- Package morse_pkg holds:
  - letter code constants Q..X
  - FSM state encoding (DRAIN, IDLE, MARK, SPACE)
  - thresholds: DOT_MIN=3, DOT_MAX=5, DASH_MIN=10, DASH_MAX=14, GAP_MIN=3, END_LEN=6
  - per-letter length/pattern constants
- The transmitter reuses the length/pattern constants from morse_pkg.
- Sub-module morse_sample_tick: SAMPLE_DIV prescaler producing the one-clock strobe. Instantiated once.

## Test plan
- All scenarios use SAMPLE_DIV=4; every scenario first waits out DRAIN after reset.
- Reset, then 6 low samples: busy falls. Then 12 high + 6 low samples: letter=011 (T), one letter_valid pulse.
- Q: marks 12,12,4,12 separated by 4-sample gaps, then 8 low: letter=000, letter_valid once, no letter_err.
- Mark of 7 samples: letter_err after the falling sample; with the macro defined, err_count=1. The next valid S (4,4,4) decodes to 010.
- Five dots (4 high / 4 low each): letter_err on the fifth mark's end; no letter_valid.
- Reset asserted mid-dash of X: no pulses, busy=1 until 6 low samples; the following W decodes to 110.
- Exhaustive loopback: transmitter driving the decoder for SW=000..111 → letter equals SW for each.
